// File: rtl/output_decider_pkg.sv
// Shared types and helpers for the output_decider block.
//   state_e        : decision FSM states
//   *_DEFAULT      : default widths / timeout used by the interface and top
//   abs_diff()     : |a - b| of two signed results, one bit wider, never overflows
package output_decider_pkg;

  localparam int RES_W_DEFAULT   = 17;
  localparam int CNT_W_DEFAULT   = 8;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Difference taken on sign-extended operands, so the extreme case
  // (-2^(W-1)) - (2^(W-1)-1) still fits and its negation is representable.
  function automatic logic [RES_W_DEFAULT:0] abs_diff(
    input logic signed [RES_W_DEFAULT-1:0] a,
    input logic signed [RES_W_DEFAULT-1:0] b
  );
    logic signed [RES_W_DEFAULT:0] d;
    d = $signed({a[RES_W_DEFAULT-1], a}) - $signed({b[RES_W_DEFAULT-1], b});
    return d[RES_W_DEFAULT] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/output_decider_if.sv
// Result / decision bus of the output_decider.
//   master : upstream neurons and downstream consumer (drive results and ack)
//   slave  : the decider itself
interface output_decider_if #(
  parameter int RES_W = 17,
  parameter int CNT_W = 8
);
  logic signed [RES_W-1:0] res0;
  logic                    res0_ready;
  logic signed [RES_W-1:0] res1;
  logic                    res1_ready;
  logic                    accept_ready;
  logic                    class_valid;
  logic                    class_ack;
  logic                    class_id;
  logic signed [RES_W-1:0] class_score;
  logic [RES_W:0]          class_margin;
  logic                    timeout_err;
  logic [CNT_W-1:0]        drop_count;
  logic [CNT_W-1:0]        timeout_count;

  modport master (
    output res0, res0_ready, res1, res1_ready, class_ack,
    input  accept_ready, class_valid, class_id, class_score, class_margin,
           timeout_err, drop_count, timeout_count
  );

  modport slave (
    input  res0, res0_ready, res1, res1_ready, class_ack,
    output accept_ready, class_valid, class_id, class_score, class_margin,
           timeout_err, drop_count, timeout_count
  );
endinterface

// File: rtl/output_decider_sat_counter.sv
// Saturating up-counter used for the drop and timeout statistics.
//   clk, rst : clock, async active-high reset
//   inc      : amount to add this cycle (0, 1 or 2)
//   count    : current value, sticks at 2^CNT_W - 1
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, inc};
    count_d = (sum > {1'b0, MAX}) ? MAX : sum[CNT_W-1:0];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/output_decider.sv
// Collects two independently-timed neuron results, picks the winning class
// and its margin, and holds the decision on a valid/ack handshake.
//   clk, rst : clock, async active-high reset
//   bus      : output_decider_if.slave (results in, decision/statistics out)
// Params: RES_W result width (abs_diff is sized for the package default),
//         TIMEOUT cycles to wait for the partner result, CNT_W counter width.
module output_decider
  import output_decider_pkg::*;
#(
  parameter int RES_W   = RES_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output_decider_if.slave   bus
);
  state_e                  state_q, state_d;
  logic signed [RES_W-1:0] cap0_q, cap0_d, cap1_q, cap1_d;
  logic                    flag0_q, flag0_d, flag1_q, flag1_d;
  logic [7:0]              timer_q, timer_d;
  logic                    class_valid_q, class_valid_d;
  logic                    class_id_q, class_id_d;
  logic signed [RES_W-1:0] class_score_q, class_score_d;
  logic [RES_W:0]          class_margin_q, class_margin_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [1:0]              drop_inc, to_inc;
  logic                    partner, repeat_p;
  logic [CNT_W-1:0]        drop_count, timeout_count;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d        = state_q;
    cap0_d         = cap0_q;
    cap1_d         = cap1_q;
    flag0_d        = flag0_q;
    flag1_d        = flag1_q;
    timer_d        = timer_q;
    class_valid_d  = class_valid_q;
    class_id_d     = class_id_q;
    class_score_d  = class_score_q;
    class_margin_d = class_margin_q;
    timeout_err_d  = 1'b0;
    drop_inc       = 2'd0;
    to_inc         = 2'd0;
    // In COLLECT exactly one flag is set: the other result is the partner.
    partner  = flag0_q ? bus.res1_ready : bus.res0_ready;
    repeat_p = flag0_q ? bus.res0_ready : bus.res1_ready;

    unique case (state_q)
      IDLE: begin
        if (bus.res0_ready) cap0_d = bus.res0;
        if (bus.res1_ready) cap1_d = bus.res1;
        if (bus.res0_ready && bus.res1_ready) begin
          state_d = DECIDE;
        end else if (bus.res0_ready || bus.res1_ready) begin
          flag0_d = bus.res0_ready;
          flag1_d = bus.res1_ready;
          timer_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        timer_d = timer_q + 8'd1;
        if (repeat_p) drop_inc = 2'd1;
        if (partner) begin
          if (flag0_q) cap1_d = bus.res1;
          else         cap0_d = bus.res0;
          flag0_d = 1'b0;
          flag1_d = 1'b0;
          state_d = DECIDE;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          to_inc        = 2'd1;
          flag0_d       = 1'b0;
          flag1_d       = 1'b0;
          state_d       = IDLE;
        end
      end
      DECIDE: begin
        drop_inc       = {1'b0, bus.res0_ready} + {1'b0, bus.res1_ready};
        class_id_d     = (cap1_q > cap0_q);          // tie keeps class 0
        class_score_d  = (cap1_q > cap0_q) ? cap1_q : cap0_q;
        class_margin_d = abs_diff(cap0_q, cap1_q);
        class_valid_d  = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        drop_inc = {1'b0, bus.res0_ready} + {1'b0, bus.res1_ready};
        if (bus.class_ack) begin
          class_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cap0_q         <= '0;
      cap1_q         <= '0;
      flag0_q        <= 1'b0;
      flag1_q        <= 1'b0;
      timer_q        <= '0;
      class_valid_q  <= 1'b0;
      class_id_q     <= 1'b0;
      class_score_q  <= '0;
      class_margin_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cap0_q         <= cap0_d;
      cap1_q         <= cap1_d;
      flag0_q        <= flag0_d;
      flag1_q        <= flag1_d;
      timer_q        <= timer_d;
      class_valid_q  <= class_valid_d;
      class_id_q     <= class_id_d;
      class_score_q  <= class_score_d;
      class_margin_q <= class_margin_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (to_inc),
    .count (timeout_count)
  );

  assign bus.accept_ready  = (state_q == IDLE) || (state_q == COLLECT);
  assign bus.class_valid   = class_valid_q;
  assign bus.class_id      = class_id_q;
  assign bus.class_score   = class_score_q;
  assign bus.class_margin  = class_margin_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.drop_count    = drop_count;
  assign bus.timeout_count = timeout_count;
endmodule

// File: tb/tb_output_decider.sv
// Directed, table-driven bench for output_decider. Inputs are driven 1 time
// unit after a rising edge and outputs are sampled at the same point, so a
// value set "in cycle T" is captured by the edge that ends cycle T.
module tb_output_decider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_bad = 0;

  output_decider_if #(.RES_W(17), .CNT_W(8)) bus ();

  output_decider #(.RES_W(17), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [16:0] r0;
    logic signed [16:0] r1;
    logic               id;
    logic signed [16:0] score;
    logic [17:0]        margin;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance one clock; single-cycle pulses and ack drop afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    bus.res0_ready = 1'b0;
    bus.res1_ready = 1'b0;
    bus.class_ack  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_accept"}, bus.accept_ready, 1);
    check({tag, "_valid"},  bus.class_valid, 0);
    check({tag, "_id"},     bus.class_id, 0);
    check({tag, "_score"},  bus.class_score, 0);
    check({tag, "_margin"}, bus.class_margin, 0);
    check({tag, "_terr"},   bus.timeout_err, 0);
    check({tag, "_drops"},  bus.drop_count, 0);
    check({tag, "_tocnt"},  bus.timeout_count, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.res0 = '0; bus.res1 = '0;
    bus.res0_ready = 1'b0; bus.res1_ready = 1'b0; bus.class_ack = 1'b0;

    vecs[0] = '{17'(100),    17'(-50),    1'b0, 17'(100),    18'(150)};
    vecs[1] = '{17'(-65536), 17'(-65536), 1'b0, 17'(-65536), 18'(0)};
    vecs[2] = '{17'(-65536), 17'(65535),  1'b1, 17'(65535),  18'(131071)};
    vecs[3] = '{17'(65535),  17'(-65536), 1'b0, 17'(65535),  18'(131071)};
    vecs[4] = '{17'(-1),     17'(0),      1'b1, 17'(0),      18'(1)};
    vecs[5] = '{17'(42),     17'(42),     1'b0, 17'(42),     18'(0)};

    #1;
    do_reset();

    // Simultaneous capture at T, ack in T+4.
    bus.res0 = 17'(100); bus.res1 = 17'(-50);
    bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    step();                                             // T+1 DECIDE
    check("sim_t1_valid", bus.class_valid, 0);
    check("sim_t1_accept", bus.accept_ready, 0);
    step();                                             // T+2 HOLD
    check("sim_valid", bus.class_valid, 1);
    check("sim_id", bus.class_id, 0);
    check("sim_score", bus.class_score, 100);
    check("sim_margin", bus.class_margin, 150);
    step();                                             // T+3
    check("sim_t3_valid", bus.class_valid, 1);
    step();                                             // T+4
    bus.class_ack = 1'b1;
    step();                                             // T+5
    check("sim_t5_valid", bus.class_valid, 0);
    check("sim_t5_accept", bus.accept_ready, 1);

    // Table: both ready together, ack on the first HOLD cycle.
    for (int i = 0; i < 6; i++) begin
      bus.res0 = vecs[i].r0; bus.res1 = vecs[i].r1;
      bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
      step();
      step();
      check($sformatf("vec%0d_valid", i), bus.class_valid, 1);
      check($sformatf("vec%0d_id", i), bus.class_id, vecs[i].id);
      check($sformatf("vec%0d_score", i), bus.class_score, vecs[i].score);
      check($sformatf("vec%0d_margin", i), bus.class_margin, vecs[i].margin);
      bus.class_ack = 1'b1;
      step();
      check($sformatf("vec%0d_acked", i), bus.class_valid, 0);
    end

    // Staggered arrival with a repeat of the captured result.
    do_reset();
    bus.res1 = 17'(300); bus.res1_ready = 1'b1;
    step();                                             // T+1
    step();                                             // T+2
    bus.res1 = 17'(7); bus.res1_ready = 1'b1;
    step();                                             // T+3
    step();                                             // T+4
    step();                                             // T+5
    bus.res0 = 17'(299); bus.res0_ready = 1'b1;
    step();                                             // T+6
    check("stag_t6_valid", bus.class_valid, 0);
    step();                                             // T+7
    check("stag_valid", bus.class_valid, 1);
    check("stag_id", bus.class_id, 1);
    check("stag_score", bus.class_score, 300);
    check("stag_margin", bus.class_margin, 1);
    check("stag_drops", bus.drop_count, 1);
    bus.class_ack = 1'b1;
    step();

    // Timeout: lone res0 at T, timeout cycle is T+16.
    do_reset();
    bus.res0 = 17'(11); bus.res0_ready = 1'b1;
    step();                                             // T+1
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("to_quiet_%0d", k), bus.timeout_err, 0);
      step();
    end                                                 // T+17
    check("to_err", bus.timeout_err, 1);
    check("to_count", bus.timeout_count, 1);
    check("to_valid", bus.class_valid, 0);
    step();
    check("to_err_pulse", bus.timeout_err, 0);

    // Partner exactly on the timeout cycle wins.
    bus.res0 = 17'(5); bus.res0_ready = 1'b1;
    step();                                             // T+1
    repeat (15) step();                                 // T+16
    bus.res1 = 17'(9); bus.res1_ready = 1'b1;
    step();                                             // T+17
    check("late_terr", bus.timeout_err, 0);
    check("late_tocnt", bus.timeout_count, 1);
    step();                                             // T+18
    check("late_valid", bus.class_valid, 1);
    check("late_id", bus.class_id, 1);
    check("late_score", bus.class_score, 9);
    check("late_margin", bus.class_margin, 4);
    bus.class_ack = 1'b1;
    step();

    // Backpressure: 300 HOLD cycles with both readies pulsing.
    do_reset();
    bus.res0 = 17'(10); bus.res1 = 17'(20);
    bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 300; i++) begin
      bus.res0 = 17'(i); bus.res1 = 17'(-i);
      bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
      step();
      check("bp_valid", bus.class_valid, 1);
      check("bp_score", bus.class_score, 20);
      check("bp_margin", bus.class_margin, 10);
      check("bp_drops", bus.drop_count, (2 * (i + 1) > 255) ? 255 : 2 * (i + 1));
    end
    check("bp_id", bus.class_id, 1);
    bus.class_ack = 1'b1; bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    step();
    check("bp_acked", bus.class_valid, 0);
    check("bp_drops_sat", bus.drop_count, 255);

    // Async reset while in COLLECT with both counters non-zero.
    do_reset();
    bus.res0 = 17'(3); bus.res0_ready = 1'b1;
    step();
    repeat (16) step();
    check("rc_tocnt_pre", bus.timeout_count, 1);
    bus.res1 = 17'(4); bus.res1_ready = 1'b1;
    step();
    bus.res1_ready = 1'b1;
    step();
    check("rc_drops_pre", bus.drop_count, 1);
    #2 rst = 1'b1;
    #1 check_reset_state("rc");
    #1 rst = 1'b0;
    step();
    check("rc_after_valid", bus.class_valid, 0);

    // Async reset while holding a decision.
    bus.res0 = 17'(-7); bus.res1 = 17'(3);
    bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;
    step();
    step();
    check("rh_valid_pre", bus.class_valid, 1);
    check("rh_margin_pre", bus.class_margin, 10);
    bus.res0_ready = 1'b1;
    step();
    check("rh_drops_pre", bus.drop_count, 1);
    #2 rst = 1'b1;
    #1 check_reset_state("rh");
    #1 rst = 1'b0;
    step();
    check("rh_after_accept", bus.accept_ready, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/output_decider.md
Name: output_decider

Overview:
- Consumer at the far end of the output-layer result interface.
- Collects the two signed 17-bit neuron results (res0, res1) and their independent ready pulses, which may arrive on different cycles.
- Decides the winning class and its margin, then presents the decision downstream on a valid/ack handshake.
- Tells the upstream sequencer when it may launch the next inference, and counts dropped or orphaned results.

Parameters:
- RES_W, 17, width of each signed neuron result.
- TIMEOUT, 16, cycles allowed in COLLECT for the missing partner result; legal range 2..255.
- CNT_W, 8, width of the saturating drop and timeout counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- res0  in  RES_W  signed result of output neuron 0.
- res0_ready  in  1  single-cycle pulse; res0 is valid this cycle.
- res1  in  RES_W  signed result of output neuron 1.
- res1_ready  in  1  single-cycle pulse; res1 is valid this cycle.
- accept_ready  out  1  high in IDLE or COLLECT; upstream may issue input_ready.
- class_valid  out  1  decision valid; held until acknowledged.
- class_ack  in  1  downstream accepts the decision.
- class_id  out  1  winning class: 0 = res0, 1 = res1.
- class_score  out  RES_W  signed winning result value.
- class_margin  out  RES_W+1  unsigned |res0 - res1|.
- timeout_err  out  1  one-cycle pulse when COLLECT times out.
- drop_count  out  CNT_W  saturating count of discarded ready pulses.
- timeout_count  out  CNT_W  saturating count of timeouts.

Behaviour:
- Reset (asynchronous, while rst high): state = IDLE. All outputs 0, except accept_ready = 1 (combinational from IDLE). Capture registers, capture flags, timer and counters cleared.
- Reset mid-operation aborts any partial collection or pending decision with no output pulse.
- States: IDLE, COLLECT, DECIDE, HOLD. One-hot or binary encoding is permitted.
- IDLE:
  - Both ready pulses in the same cycle: capture both, go to DECIDE.
  - Exactly one ready pulse: capture it, set its flag, clear the timer, go to COLLECT.
  - No ready pulse: stay in IDLE.
- COLLECT:
  - Partner ready pulse: capture it, go to DECIDE.
  - Repeat pulse of an already-captured result: discard it, keep the original value, drop_count += 1.
  - Partner and repeat pulse in the same cycle: capture the partner, drop the repeat (+1), go to DECIDE.
  - Timer increments every cycle. When timer == TIMEOUT-1 and no partner pulse arrives: pulse timeout_err, timeout_count += 1, clear flags, go to IDLE.
  - A partner pulse on the timeout cycle wins; no timeout is raised.
- DECIDE (exactly one cycle), registered compute:
  - class_id = (res1 > res0) ? 1 : 0. A tie selects class 0.
  - class_score = the selected value.
  - class_margin = |res0 - res1|, computed at RES_W+1 bits, sign-extended difference, no overflow. Maximum is 131071 for RES_W = 17.
  - Next state is HOLD.
- HOLD:
  - class_valid = 1. class_id, class_score and class_margin are stable until ack.
  - class_ack high: go to IDLE next cycle; class_valid is 0 from that cycle.
  - Ack on the first HOLD cycle is legal.
- class_ack outside HOLD is ignored.
- Latency: both ready in cycle T gives class_valid high in cycle T+2. If the second result arrives in cycle T, the same latency applies from T.
- Drops: any ready pulse during DECIDE or HOLD, including the ack cycle, is discarded.
  - drop_count += 1 per pulse; simultaneous res0_ready and res1_ready add 2.
  - drop_count and timeout_count saturate at 2^CNT_W - 1 and never wrap.
- Outputs are registered, except accept_ready, which is decoded from state.

Decomposition:
- Package output_decider_pkg:
  - state enum: IDLE, COLLECT, DECIDE, HOLD.
  - RES_W default constant.
  - function abs_diff (signed RES_W in, unsigned RES_W+1 out).
- One natural sub-module, sat_counter (CNT_W-wide, inc amount 0/1/2, saturating). It is instantiated for both counters.

Test Plan:
- Simultaneous capture: rst, then res0 = 100 and res1 = -50 with both ready at T. Required: class_valid at T+2, class_id = 0, class_score = 100, class_margin = 150; ack at T+4, then class_valid = 0 and accept_ready = 1 at T+5.
- Staggered arrival: res1 = 300 ready at T, res0 = 299 ready at T+5. Required: class_valid at T+7, class_id = 1, class_score = 300, class_margin = 1; repeat res1_ready = 7 at T+2 leaves the result unchanged and gives drop_count = 1.
- Tie and extremes: res0 = res1 = -65536 gives class_id = 0 and margin 0. res0 = -65536, res1 = 65535 gives class_id = 1 and margin = 131071.
- Timeout: only res0_ready at T. Required: timeout_err pulses at T+16, state returns to IDLE, timeout_count = 1. A partner pulse exactly at T+16 instead gives a decision and no timeout.
- Backpressure and drops: hold class_ack low for 300 cycles while pulsing both readies every cycle in HOLD. Required: outputs stable, drop_count saturates at 255.
- Reset mid-operation: assert rst in COLLECT and again in HOLD. Required: class_valid, class_id, class_score, class_margin, timeout_err and both counters all return to 0 asynchronously; accept_ready = 1.
